// File: rtl/bcd_counter_mux_segdis.sv
// Multi-digit packed-BCD up/down counter with a time-multiplexed
// 8-position common-select 7-segment display front-end.
// One tick prescaler paces counting; an independent scan prescaler
// walks the digit index. All outputs are registered.

// One BCD decade: steps when its ripple input is set and reports
// carry/borrow out when it wraps.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       step,
  output logic [3:0] nxt,
  output logic       cout
);
  // Next-digit value and ripple out for one decade
  always_comb begin
    nxt  = d;
    cout = 1'b0;
    if (step) begin
      if (up) begin
        if (d >= 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_counter_mux_segdis #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [7:0]            seg_com,
  output logic [7:0]            seg_data
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DIGITS - 1);

  logic [TW-1:0]             tcnt;
  logic [SW-1:0]             scnt;
  logic [DW-1:0]             didx;
  logic [DIGITS-1:0][3:0]    dig;
  logic [DIGITS-1:0][3:0]    dig_nxt;
  logic [DIGITS:0]           rip;
  logic                      tick;

  assign tick   = en && (tcnt == TMAX);
  assign rip[0] = 1'b1;
  assign count  = dig;

  // Ripple chain: digit g steps only when every lower digit wrapped
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .d    (dig[g]),
      .up   (up),
      .step (rip[g]),
      .nxt  (dig_nxt[g]),
      .cout (rip[g+1])
    );
  end

  // 7-segment decode {dp,g,f,e,d,c,b,a}; non-BCD blanks the digit
  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'b0011_1111;
      4'd1:    seg7 = 8'b0000_0110;
      4'd2:    seg7 = 8'b0101_1011;
      4'd3:    seg7 = 8'b0100_1111;
      4'd4:    seg7 = 8'b0110_0110;
      4'd5:    seg7 = 8'b0110_1101;
      4'd6:    seg7 = 8'b0111_1101;
      4'd7:    seg7 = 8'b0000_0111;
      4'd8:    seg7 = 8'b0111_1111;
      4'd9:    seg7 = 8'b0110_0111;
      default: seg7 = 8'b0000_0000;
    endcase
  endfunction

  // Tick prescaler, count register and wrap pulse; clr beats a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      dig   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      tcnt  <= '0;
      dig   <= '0;
      carry <= 1'b0;
    end else begin
      carry <= tick && rip[DIGITS];
      if (en) tcnt <= tick ? '0 : tcnt + TW'(1);
      if (tick) dig <= dig_nxt;
    end
  end

  // Free-running scan prescaler and digit index; unaffected by en/clr
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      didx <= '0;
    end else if (scnt == SMAX) begin
      scnt <= '0;
      didx <= (didx == DMAX) ? '0 : didx + DW'(1);
    end else begin
      scnt <= scnt + SW'(1);
    end
  end

  // Display registers sample the current digit, so they trail by a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_com  <= 8'hFF;
      seg_data <= 8'h00;
    end else begin
      seg_com  <= ~(8'h80 >> didx);
      seg_data <= seg7(dig[didx]);
    end
  end
endmodule

// File: tb/tb_bcd_counter_mux_segdis.sv
// Scoreboard bench: a decimal-integer reference model pushes the expected
// outputs for every cycle it drives; the observed outputs are queued after
// the edge and each test task drains and compares both queues.
module tb_bcd_counter_mux_segdis;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 2;
  localparam int SCAN_DIV = 4;

  typedef struct packed {
    logic [15:0] count;
    logic        carry;
    logic [7:0]  com;
    logic [7:0]  seg;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, up = 1'b1, clr = 1'b0;
  logic [4*DIGITS-1:0] count;
  logic carry;
  logic [7:0] seg_com, seg_data;

  int n_chk = 0;
  int n_fail = 0;

  obs_t exp_q[$];
  obs_t got_q[$];

  // reference model state
  int m_val = 0, m_tcnt = 0, m_scnt = 0, m_didx = 0;
  logic m_carry = 1'b0;
  logic [7:0] m_com = 8'hFF, m_seg = 8'h00;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67};
  logic [7:0] scan_com [4] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF};
  logic [7:0] scan_seg [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};

  bcd_counter_mux_segdis #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .count(count), .carry(carry), .seg_com(seg_com), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Drive one cycle, advance the model, queue expected and observed
  task automatic step(input logic r, input logic c, input logic e, input logic u);
    obs_t x, o;
    int p;
    bit tk;
    rst = r; clr = c; en = e; up = u;
    if (r) begin
      m_val = 0; m_tcnt = 0; m_scnt = 0; m_didx = 0;
      m_carry = 1'b0; m_com = 8'hFF; m_seg = 8'h00;
    end else begin
      p = 1;
      for (int i = 0; i < m_didx; i++) p = p * 10;
      m_com = 8'hFF;
      m_com[7 - m_didx] = 1'b0;
      m_seg = seg_tab[(m_val / p) % 10];
      tk = e && (m_tcnt == TICK_DIV - 1);
      m_carry = 1'b0;
      if (c) begin
        m_val = 0; m_tcnt = 0;
      end else if (e) begin
        m_tcnt = tk ? 0 : m_tcnt + 1;
        if (tk) begin
          if (u) begin
            if (m_val == 9999) m_carry = 1'b1;
            m_val = (m_val + 1) % 10000;
          end else begin
            if (m_val == 0) m_carry = 1'b1;
            m_val = (m_val + 9999) % 10000;
          end
        end
      end
      if (m_scnt == SCAN_DIV - 1) begin
        m_scnt = 0;
        m_didx = (m_didx + 1) % DIGITS;
      end else begin
        m_scnt = m_scnt + 1;
      end
    end
    x.count = to_bcd(m_val);
    x.carry = m_carry;
    x.com   = m_com;
    x.seg   = m_seg;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    o.count = count; o.carry = carry; o.com = seg_com; o.seg = seg_data;
    got_q.push_back(o);
  endtask

  task automatic test_reset;
    obs_t e, g;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0 || g.carry !== 1'b0 || g.com !== 8'hFF || g.seg !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state got %h/%b/%h/%h want 0000/0/ff/00", g.count, g.carry, g.com, g.seg);
    end
    step(0, 0, 0, 1);
    g = got_q[$];
    n_chk++;
    if (g.com !== 8'h7F || g.seg !== 8'h3F) begin
      n_fail++;
      $display("FAIL reset_release got com=%h seg=%h want 7f/3f", g.com, g.seg);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL reset_sb got %h want %h", g, e); end
    end
  endtask

  task automatic test_count_up;
    obs_t e, g;
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0010) begin
      n_fail++; $display("FAIL count_up_20 got %h want 0010", g.count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e || g.carry !== 1'b0) begin n_fail++; $display("FAIL count_up got %h want %h", g, e); end
    end
  endtask

  task automatic test_wrap_up;
    obs_t e, g;
    int n = 0;
    while (m_val != 9999 && n < 25000) begin step(0, 0, 1, 1); n++; end
    if (m_val != 9999) begin n_fail++; $display("FAIL wrap_up_preload timeout"); end
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0000 || g.carry !== 1'b1) begin
      n_fail++; $display("FAIL wrap_up_edge got %h/%b want 0000/1", g.count, g.carry);
    end
    step(0, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0000 || g.carry !== 1'b0) begin
      n_fail++; $display("FAIL wrap_up_pulse got %h/%b want 0000/0", g.count, g.carry);
    end
    step(0, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0001 || g.carry !== 1'b0) begin
      n_fail++; $display("FAIL wrap_up_next got %h/%b want 0001/0", g.count, g.carry);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL wrap_up got %h want %h", g, e); end
    end
  endtask

  task automatic test_down;
    obs_t e, g;
    int n = 0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0000 || g.carry !== 1'b0) begin
      n_fail++; $display("FAIL down_to_zero got %h/%b want 0000/0", g.count, g.carry);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h9999 || g.carry !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap got %h/%b want 9999/1", g.count, g.carry);
    end
    step(0, 1, 0, 1);
    while (m_val != 100 && n < 400) begin step(0, 0, 1, 1); n++; end
    if (m_val != 100) begin n_fail++; $display("FAIL down_preload timeout"); end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0099 || g.carry !== 1'b0) begin
      n_fail++; $display("FAIL down_borrow got %h/%b want 0099/0", g.count, g.carry);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL down got %h want %h", g, e); end
    end
  endtask

  task automatic test_clr;
    obs_t e, g;
    int n = 0;
    step(0, 1, 0, 1);
    while (m_val != 42 && n < 200) begin step(0, 0, 1, 1); n++; end
    if (m_val != 42) begin n_fail++; $display("FAIL clr_preload timeout"); end
    step(0, 0, 1, 1);
    // tcnt is now at its last value: this clr lands on a tick
    step(0, 1, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0000 || g.carry !== 1'b0) begin
      n_fail++; $display("FAIL clr_on_tick got %h/%b want 0000/0", g.count, g.carry);
    end
    step(0, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0000) begin
      n_fail++; $display("FAIL clr_tcnt_reset got %h want 0000", g.count);
    end
    step(0, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0001) begin
      n_fail++; $display("FAIL clr_resume got %h want 0001", g.count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL clr got %h want %h", g, e); end
    end
  endtask

  task automatic test_scan;
    obs_t e, g;
    int n = 0;
    logic [7:0] prev;
    step(0, 1, 0, 1);
    while (m_val != 1234 && n < 3000) begin step(0, 0, 1, 1); n++; end
    if (m_val != 1234) begin n_fail++; $display("FAIL scan_preload timeout"); end
    // align so the last observed cycle is the first one showing digit 0
    n = 0;
    prev = m_com;
    step(0, 0, 0, 1);
    while (!(m_com == 8'h7F && prev != 8'h7F) && n < 40) begin
      prev = m_com; step(0, 0, 0, 1); n++;
    end
    if (n >= 40) begin n_fail++; $display("FAIL scan_align timeout"); end
    while (exp_q.size() > 1) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL scan_pre got %h want %h", g, e); end
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step(0, 0, 0, 1);
      g = got_q[$];
      n_chk++;
      if (g.com !== scan_com[k/4] || g.seg !== scan_seg[k/4] || g.count !== 16'h1234) begin
        n_fail++;
        $display("FAIL scan_k%0d got %h/%h/%h want %h/%h/1234", k, g.com, g.seg, g.count,
                 scan_com[k/4], scan_seg[k/4]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL scan got %h want %h", g, e); end
    end
  endtask

  task automatic test_rst_mid;
    obs_t e, g;
    int n = 0;
    step(0, 1, 0, 1);
    while (m_val != 567 && n < 1500) begin step(0, 0, 1, 1); n++; end
    if (m_val != 567) begin n_fail++; $display("FAIL rst_mid_preload timeout"); end
    if (m_scnt == 0) step(0, 0, 0, 1);
    step(1, 0, 1, 1);
    g = got_q[$];
    n_chk++;
    if (g.count !== 16'h0 || g.com !== 8'hFF || g.seg !== 8'h00 || g.carry !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got %h/%h/%h want 0000/ff/00", g.count, g.com, g.seg);
    end
    step(0, 0, 0, 1);
    g = got_q[$];
    n_chk++;
    if (g.com !== 8'h7F || g.seg !== 8'h3F || g.count !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_resume got %h/%h/%h want 0000/7f/3f", g.count, g.com, g.seg);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL rst_mid_sb got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_down();
    test_clr();
    test_scan();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_counter_mux_segdis.md
# bcd_counter_mux_segdis

Parametrised multi-digit BCD counter driving a time-multiplexed 8-digit common-select 7-segment display. A prescaler turns the system clock into count ticks. The counter then counts up or down in packed BCD with ripple carry/borrow across DIGITS decades. A second, free-running prescaler scans one digit at a time onto the shared segment bus. It succeeds the single-digit, unscanned counter display as the display front-end for board-level counter and timer designs.

## Interface
Parameters:
- DIGITS, 4, number of BCD decades counted and displayed; legal 1..8
- TICK_DIV, 1000000, clk cycles per count step; legal ≥ 1
- SCAN_DIV, 10000, clk cycles each digit is held on the display; legal ≥ 1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset; highest priority
- en  in  1  count enable; low freezes tick prescaler and count
- up  in  1  direction; 1 = increment, 0 = decrement; sampled on tick
- clr  in  1  synchronous clear of count and tick prescaler; priority over tick
- count  out  4*DIGITS  packed BCD value; digit i at bits [4i+3:4i]; digit 0 is least significant
- carry  out  1  one-cycle pulse on full-range wrap (up: all 9s→0, down: all 0s→9s)
- seg_com  out  8  digit select, active-low; digit i drives seg_com[7-i]; unused bits held 1
- seg_data  out  8  segments, active-high, {dp,g,f,e,d,c,b,a}; dp always 0

## Operation
- Tick prescaler tcnt counts 0..TICK_DIV-1 while en=1. A tick occurs when en=1 and tcnt=TICK_DIV-1; tcnt then wraps to 0. With TICK_DIV=1, every enabled cycle is a tick.
- Up on tick: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. Ripple through all DIGITS. If all digits are 9, result is all 0 and carry=1.
- Down on tick: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. If all digits are 0, result is all 9 and carry=1.
- Priority per edge: rst > clr > tick > hold.
  - clr: count=0, tcnt=0, carry=0.
  - clr with a coincident tick: no step and no carry.
- en=0: tcnt and count hold. carry=0.
- up is honoured only at the tick edge; changing it between ticks has no other effect.
- Scan prescaler scnt runs 0..SCAN_DIV-1 regardless of en and clr. At wrap, digit index didx advances 0→1→…→DIGITS-1→0. With DIGITS=1, didx stays 0.
- Segment decode, one value per digit 0..9:
  - 0 → 0011_1111
  - 1 → 0000_0110
  - 2 → 0101_1011
  - 3 → 0100_1111
  - 4 → 0110_0110
  - 5 → 0110_1101
  - 6 → 0111_1101
  - 7 → 0000_0111
  - 8 → 0111_1111
  - 9 → 0110_0111
  - Any non-BCD nibble → 0000_0000. This is unreachable but must be defined.
- seg_com has exactly one 0 bit, at position 7-didx, outside reset.

## Timing
- Reset (rst=1 at an edge) sets all outputs and state:
  - count=0, carry=0, tcnt=0, scnt=0, didx=0
  - seg_com=1111_1111, seg_data=0000_0000
- All outputs are registered. No combinational path from any input to any output.
- count and carry change on the tick edge itself. carry is high for exactly that one cycle.
- Display registers are one cycle behind count and didx:
  - seg_com and seg_data show digit didx of count as it stood on the previous cycle.
  - First cycle after reset release: seg_com=0111_1111, seg_data=0011_1111.
- Each digit occupies exactly SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.
- rst mid-count or mid-scan: every register returns to its reset value on that edge. The display resumes at digit 0.
- clr does not disturb scan timing.

## Test plan
Directed tests use DIGITS=4, TICK_DIV=2, SCAN_DIV=4.
- Reset then en=1, up=1 for 20 cycles → count steps every 2 cycles: 0000, 0001, … 0010 after 20 cycles; carry never high.
- Preload via 9999 up-ticks, then one more tick → count=0000, carry high one cycle. Next tick → 0001, carry low.
- From 0000, up=0, one tick → count=9999 with carry pulse. From 0100, one down-tick → 0099 (borrow ripples across two digits).
- clr asserted on a tick cycle at count=0042 → count=0000, no step, carry=0, tcnt=0. Scan continues unchanged.
- With count=1234 and en=0, watch 16 cycles → seg_com cycles through 0111_1111, 1011_1111, 1101_1111, 1110_1111, holding each for 4 cycles. seg_data shows 4, 3, 2, 1 patterns (0110_0110, 0100_1111, 0101_1011, 0000_0110). count holds.
- rst pulsed mid-frame at count=0567 → next cycle count=0, seg_com=1111_1111, seg_data=0. The following cycle shows digit 0 with seg_data=0011_1111.
